// File: rtl/cu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cu_sequencer_if : control/handshake/status bundle of the CU sequencer    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface cu_sequencer_if;
  logic        run;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic [3:0]  StateRegister;
  logic        illegal;
  logic        timeout;
  logic [31:0] instret;

  modport master (
    output run, opcode, mem_ready,
    input  StateRegister, illegal, timeout, instret
  );

  modport slave (
    input  run, opcode, mem_ready,
    output StateRegister, illegal, timeout, instret
  );
endinterface
`default_nettype wire

// File: rtl/cu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cu_sequencer : multicycle RV32 control-unit state sequencer              |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cu_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  wire logic     clk,
  input  wire logic     reset,
  cu_sequencer_if.slave bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
  // Last permitted wait cycle: a further mem_ready=0 here would reach MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    LOADWB   = 4'd4,
    MEMWRITE = 4'd5,
    REXEC    = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    LINK     = 4'd9,
    JAL      = 4'd10,
    UPIMM    = 4'd11,
    JALR     = 4'd12,
    IEXEC    = 4'd13,
    TRAP     = 4'd14,
    SPARE    = 4'd15
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      instret;
  logic             illegal;
  logic             timeout;

  logic             wait_inc;
  logic             retire;
  logic             set_illegal;
  logic             set_timeout;

  always_comb begin
    state_nxt   = state;
    wait_inc    = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      FETCH: begin
        if (bus.run) begin
          if (bus.mem_ready) state_nxt = DECODE;
          else               wait_inc  = 1'b1;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_nxt = MEMADDR;
          OP_RTYPE:          state_nxt = REXEC;
          OP_ITYPE:          state_nxt = IEXEC;
          OP_BRANCH:         state_nxt = BRANCH;
          OP_JAL, OP_JALR:   state_nxt = LINK;
          OP_LUI, OP_AUIPC:  state_nxt = UPIMM;
          default: begin
            state_nxt   = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADDR:  state_nxt = (op_q == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (bus.mem_ready) state_nxt = LOADWB;
        else               wait_inc  = 1'b1;
      end
      MEMWRITE: begin
        if (bus.mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      REXEC, IEXEC: state_nxt = ALUWB;
      LINK:         state_nxt = (op_q == OP_JAL) ? JAL : JALR;
      LOADWB, ALUWB, BRANCH, JAL, JALR, UPIMM: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase

    // A ready on the final permitted cycle wins; only a stalled one traps.
    if (wait_inc && (wait_cnt == WAIT_LAST)) begin
      state_nxt   = TRAP;
      set_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) op_q <= bus.opcode;
      if (state_nxt != state) wait_cnt <= '0;
      else if (wait_inc)      wait_cnt <= wait_cnt + CNT_W'(1);
      instret <= instret + 32'(retire);
      illegal <= illegal | set_illegal;
      timeout <= timeout | set_timeout;
    end
  end

  assign bus.StateRegister = state;
  assign bus.illegal       = illegal;
  assign bus.timeout       = timeout;
  assign bus.instret       = instret;

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// tb_cu_sequencer: directed and randomized checks of cu_sequencer against a
// path-table reference model.
module tb_cu_sequencer;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cu_sequencer_if bus();

  cu_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each opcode owns a fixed route of states after DECODE;
  // FETCH(0), MEMREAD(3) and MEMWRITE(5) are the handshake states.
  int          m_state   = 0;
  int          m_wait    = 0;
  int          m_q[$];
  logic [31:0] m_instret = '0;
  bit          m_ill     = 1'b0;
  bit          m_to      = 1'b0;

  task automatic model_reset();
    m_state   = 0;
    m_wait    = 0;
    m_q.delete();
    m_instret = '0;
    m_ill     = 1'b0;
    m_to      = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    bit ret;
    nxt = m_state;
    ret = 1'b0;
    if (m_state == 14) begin
      nxt = 14;
    end else if (m_state == 1) begin
      m_q.delete();
      case (bus.opcode)
        7'b0000011:             m_q = '{2, 3};
        7'b0100011:             m_q = '{2, 5};
        7'b0110011:             m_q = '{6, 7};
        7'b0010011:             m_q = '{13, 7};
        7'b1100011:             m_q = '{8};
        7'b1101111:             m_q = '{9, 10};
        7'b1100111:             m_q = '{9, 12};
        7'b0110111, 7'b0010111: m_q = '{11};
        default: ;
      endcase
      if (m_q.size() == 0) begin
        nxt   = 14;
        m_ill = 1'b1;
      end else begin
        nxt = m_q.pop_front();
      end
    end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
      if (m_state != 0 || bus.run) begin
        if (bus.mem_ready) begin
          nxt = (m_state == 0) ? 1 : (m_state == 3) ? 4 : 0;
          ret = (m_state == 5);
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            nxt  = 14;
            m_to = 1'b1;
          end
        end
      end
    end else begin
      ret = (m_state inside {4, 7, 8, 10, 11, 12});
      nxt = (m_q.size() > 0) ? m_q.pop_front() : 0;
    end
    if (nxt != m_state) m_wait = 0;
    if (ret) m_instret++;
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else       model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("state",   bus.StateRegister, m_state);
      chk("instret", bus.instret,       m_instret);
      chk("illegal", bus.illegal,       m_ill);
      chk("timeout", bus.timeout,       m_to);
    end
  end

  // Called at a falling edge; applies inputs and returns at the next falling edge.
  task automatic drive(input bit r, input bit mr, input logic [6:0] op);
    bus.run       = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_path(input string name, input logic [6:0] op, input int path[$]);
    foreach (path[i]) begin
      drive(1'b1, 1'b1, op);
      chk(name, bus.StateRegister, path[i]);
    end
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    int p[$];
    int trap_age;
    int idx;
    logic [6:0] op;

    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_state",   bus.StateRegister, 0);
    chk("rst_instret", bus.instret,       0);
    chk("rst_illegal", bus.illegal,       0);
    chk("rst_timeout", bus.timeout,       0);

    // No progress without both run and mem_ready.
    drive(1'b0, 1'b1, 7'b0110011); chk("hold_norun", bus.StateRegister, 0);
    drive(1'b1, 1'b0, 7'b0110011); chk("hold_nordy", bus.StateRegister, 0);
    pulse_reset();

    p = '{1, 6, 7, 0};
    expect_path("rtype", 7'b0110011, p);
    chk("rtype_instret", bus.instret, 1);

    pulse_reset();
    drive(1'b1, 1'b1, 7'b0000011); chk("load", bus.StateRegister, 1);
    drive(1'b1, 1'b1, 7'b0000011); chk("load", bus.StateRegister, 2);
    drive(1'b1, 0,    7'b0000011); chk("load", bus.StateRegister, 3);
    repeat (3) begin
      drive(1'b1, 1'b0, 7'b0000011); chk("load_wait", bus.StateRegister, 3);
    end
    drive(1'b1, 1'b1, 7'b0000011); chk("load", bus.StateRegister, 4);
    drive(1'b1, 1'b1, 7'b0000011); chk("load", bus.StateRegister, 0);
    chk("load_instret", bus.instret, 1);

    pulse_reset();
    p = '{1, 9, 12, 0};
    expect_path("jalr", 7'b1100111, p);
    chk("jalr_instret", bus.instret, 1);
    p = '{1, 9, 10, 0};
    expect_path("jal", 7'b1101111, p);
    chk("jal_instret", bus.instret, 2);

    pulse_reset();
    p = '{1, 14};
    expect_path("illegal_path", 7'b1111111, p);
    chk("illegal_flag", bus.illegal, 1);
    repeat (100) begin
      drive(1'($urandom), 1'($urandom), 7'($urandom));
      chk("trap_hold", bus.StateRegister, 14);
    end
    chk("trap_instret", bus.instret, 0);
    chk("trap_timeout", bus.timeout, 0);

    pulse_reset();
    drive(1'b1, 1'b1, 7'b0100011); chk("store_to", bus.StateRegister, 1);
    drive(1'b1, 1'b1, 7'b0100011); chk("store_to", bus.StateRegister, 2);
    drive(1'b1, 1'b0, 7'b0100011); chk("store_to", bus.StateRegister, 5);
    repeat (3) begin
      drive(1'b1, 1'b0, 7'b0100011); chk("store_wait", bus.StateRegister, 5);
    end
    drive(1'b1, 1'b0, 7'b0100011); chk("store_trap", bus.StateRegister, 14);
    chk("timeout_flag", bus.timeout, 1);
    chk("timeout_noill", bus.illegal, 0);

    // Ready on the last permitted wait cycle completes the store.
    pulse_reset();
    drive(1'b1, 1'b1, 7'b0100011);
    drive(1'b1, 1'b1, 7'b0100011);
    drive(1'b1, 1'b0, 7'b0100011); chk("store_edge", bus.StateRegister, 5);
    repeat (3) drive(1'b1, 1'b0, 7'b0100011);
    drive(1'b1, 1'b1, 7'b0100011); chk("store_edge_done", bus.StateRegister, 0);
    chk("store_edge_to", bus.timeout, 0);
    chk("store_edge_ret", bus.instret, 1);

    // Asynchronous reset in the middle of a load.
    pulse_reset();
    p = '{1, 6, 7, 0};
    repeat (5) expect_path("rtype5", 7'b0110011, p);
    chk("pre_reset_instret", bus.instret, 5);
    drive(1'b1, 1'b1, 7'b0000011);
    drive(1'b1, 1'b1, 7'b0000011);
    drive(1'b1, 1'b0, 7'b0000011); chk("pre_reset_state", bus.StateRegister, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_state",   bus.StateRegister, 0);
    chk("async_instret", bus.instret,       0);
    chk("async_noedge",  clk,               0);
    reset = 1'b0;
    @(negedge clk);

    trap_age = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 14) trap_age++;
      else               trap_age = 0;
      if (trap_age > 3) begin
        pulse_reset();
        trap_age = 0;
      end
      idx = int'($urandom_range(0, 9));
      op  = (idx == 9) ? 7'($urandom) : ops[idx];
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, op);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset; all state changes on the rising clk edge.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- run  in  1  sequencing enable; 0 holds the FSM in FETCH before it starts a fetch
- opcode  in  7  instruction opcode from the instruction register; valid in DECODE
- mem_ready  in  1  memory handshake; access completes on the cycle it is high
- StateRegister  out  4  current state code, feeds the control-signal decoder
- illegal  out  1  sticky; illegal opcode trapped
- timeout  out  1  sticky; memory handshake timed out
- instret  out  32  retired-instruction count
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum cycles spent waiting in one memory state.

Function
REQ-004 SHALL use these state codes: 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 LOADWB, 5 MEMWRITE, 6 REXEC, 7 ALUWB, 8 BRANCH, 9 LINK, 10 JAL, 11 UPIMM, 12 JALR, 13 IEXEC, 14 TRAP.
REQ-005 FETCH SHALL do the following:
- run=0: stay in FETCH without touching the timeout counter.
- run=1 and mem_ready=1: go to DECODE.
- otherwise: stay in FETCH.
REQ-006 DECODE SHALL capture opcode into an internal register op_q and branch on it:
- 0000011 or 0100011: MEMADDR.
- 0110011: REXEC.
- 0010011: IEXEC.
- 1100011: BRANCH.
- 1101111 or 1100111: LINK.
- 0110111 or 0010111: UPIMM.
- any other opcode: TRAP.
REQ-007 MEMADDR SHALL go to MEMREAD if op_q=0000011 and to MEMWRITE if op_q=0100011.
REQ-008 MEMREAD SHALL go to LOADWB when mem_ready=1 and otherwise stay in MEMREAD.
REQ-009 MEMWRITE SHALL go to FETCH when mem_ready=1 and otherwise stay in MEMWRITE.
REQ-010 REXEC and IEXEC SHALL each go to ALUWB.
REQ-011 LINK SHALL go to JAL if op_q=1101111 and to JALR if op_q=1100111.
REQ-012 LOADWB, ALUWB, BRANCH, JAL, JALR and UPIMM SHALL each go to FETCH unconditionally; these are the retiring states.
REQ-013 MEMWRITE SHALL also count as a retiring state on its exit cycle.
REQ-014 instret SHALL increment by 1 on each retiring-state exit and wrap from 0xFFFFFFFF to 0.
REQ-015 A wait counter (8 bits minimum) SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle the state waits with mem_ready=0.
- FETCH counts only while run=1.
REQ-016 If the wait counter reaches MEM_TIMEOUT while mem_ready=0, the FSM SHALL go to TRAP and set timeout.
- mem_ready=1 on that same cycle takes priority and completes the access normally.
REQ-017 Entering TRAP from DECODE SHALL set illegal.
REQ-018 TRAP SHALL be absorbing: it ignores run, mem_ready and opcode until reset, and does not increment instret.
REQ-019 Code 15 SHALL go to FETCH on the next clock without setting any flag.
REQ-020 REXEC, IEXEC, BRANCH, JAL, JALR, UPIMM, LINK and MEMADDR SHALL last exactly one cycle each.
REQ-021 StateRegister SHALL be driven directly from the state register with no combinational path from inputs.

Reset
REQ-022 Asserting reset at any time SHALL immediately force, independent of clk:
- StateRegister=0 (FETCH)
- op_q=0
- wait counter=0
- instret=0
- illegal=0
- timeout=0
REQ-023 Reset asserted mid-access (MEMREAD or MEMWRITE) SHALL abandon the access without retiring it.
REQ-024 After reset deasserts, the first state transition SHALL occur on the first rising clk edge with run=1 and mem_ready=1.

Verification
REQ-025 R-type: run=1, mem_ready=1 always, opcode=0110011 -> state sequence 0,1,6,7,0; instret=1 after 4 clocks.
REQ-026 Load with wait: opcode=0000011, mem_ready low for 3 cycles in MEMREAD -> sequence 0,1,2,3,3,3,3,4,0; instret=1.
REQ-027 JALR: opcode=1100111 -> 0,1,9,12,0. JAL: opcode=1101111 -> 0,1,9,10,0. Each retires once.
REQ-028 Illegal opcode 1111111 -> 0,1,14; illegal=1; state stays 14 for 100 further cycles whatever the inputs; instret unchanged.
REQ-029 Timeout: store with mem_ready held 0 and MEM_TIMEOUT=4 -> state 14 after 4 wait cycles in MEMWRITE; timeout=1; illegal=0.
REQ-030 Reset pulsed asynchronously while in state 3 with instret=5 -> StateRegister=0 and instret=0 before the next clk edge.
